debouncer: RTL and testbench

Per-bit button/switch debouncer that sits directly upstream of `edge_detector` in the input path (pins → synchronizer → `debouncer` → `edge_detector`). It takes already-synchronized but bouncy level signals and emits clean levels. A level goes high only after the input has been high on a fixed number of consecutive slow sample ticks. It drops on the first clock the input is seen low. Its output feeds `edge_detector.signal_in` directly, bit for bit.

---
 rtl/fpga_lab_pkg.sv | 10 +
 rtl/sample_pulse_gen.sv | 35 +++
 rtl/debouncer.sv | 51 +++++
 tb/tb_debouncer.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/fpga_lab_pkg.sv
// Project-wide constants shared by the input-path blocks.
package fpga_lab_pkg;

  localparam int CLK_FREQ_HZ             = 125_000_000;
  // 500 us per sample tick at 125 MHz
  localparam int DEBOUNCE_SAMPLE_CNT_MAX = 62500;
  // 200 ticks of 500 us = 100 ms of stable high before the level is accepted
  localparam int DEBOUNCE_PULSE_CNT_MAX  = 200;

endpackage : fpga_lab_pkg

// File: rtl/sample_pulse_gen.sv
// Free-running wrapping counter that produces a one-cycle sample tick
// every SAMPLE_CNT_MAX clocks. The tick is registered, so it is high
// exactly while the counter holds SAMPLE_CNT_MAX-1 and low in reset.
module sample_pulse_gen #(
  parameter int SAMPLE_CNT_MAX = 62500,
  parameter int CNT_WIDTH      = (SAMPLE_CNT_MAX > 1) ? $clog2(SAMPLE_CNT_MAX) : 1
) (
  input  logic clk,
  input  logic rst_n,
  output logic sample_pulse
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(SAMPLE_CNT_MAX - 1);

  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] cnt_next;

  // Next counter value: wrap to zero after the last count
  always_comb begin
    cnt_next = (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
  end

  // Counter and tick register; tick is precomputed from the next count
  // so it lines up with the counter sitting at its last value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      sample_pulse <= 1'b0;
    end else begin
      cnt          <= cnt_next;
      sample_pulse <= (cnt_next == CNT_LAST);
    end
  end

endmodule : sample_pulse_gen

// File: rtl/debouncer.sv
// Per-bit debouncer. A bit's output rises only after its input has been
// high on PULSE_CNT_MAX consecutive sample ticks, and falls on the first
// clock the input is seen low. All bits share one sample tick generator.
module debouncer
  import fpga_lab_pkg::*;
#(
  parameter int WIDTH              = 1,
  parameter int SAMPLE_CNT_MAX     = DEBOUNCE_SAMPLE_CNT_MAX,
  parameter int PULSE_CNT_MAX      = DEBOUNCE_PULSE_CNT_MAX,
  parameter int WRAPPING_CNT_WIDTH = (SAMPLE_CNT_MAX > 1) ? $clog2(SAMPLE_CNT_MAX) : 1,
  parameter int SAT_CNT_WIDTH      = $clog2(PULSE_CNT_MAX) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] glitchy_signal,
  output logic [WIDTH-1:0] debounced_signal
);

  localparam logic [SAT_CNT_WIDTH-1:0] SAT_MAX = SAT_CNT_WIDTH'(PULSE_CNT_MAX);

  logic sample_pulse;

  sample_pulse_gen #(
    .SAMPLE_CNT_MAX (SAMPLE_CNT_MAX),
    .CNT_WIDTH      (WRAPPING_CNT_WIDTH)
  ) u_sample_pulse_gen (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_pulse (sample_pulse)
  );

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic [SAT_CNT_WIDTH-1:0] sat_cnt;

    // Saturating qualification counter: a low input clears it on any
    // cycle (even a tick cycle), otherwise each tick adds one until MAX
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sat_cnt <= '0;
      end else if (!glitchy_signal[i]) begin
        sat_cnt <= '0;
      end else if (sample_pulse && (sat_cnt < SAT_MAX)) begin
        sat_cnt <= sat_cnt + 1'b1;
      end
    end

    // Output decoded straight from the counter; no extra register stage
    assign debounced_signal[i] = (sat_cnt == SAT_MAX);
  end

endmodule : debouncer

// File: tb/tb_debouncer.sv
// Directed bench for debouncer (WIDTH=2, SAMPLE_CNT_MAX=4, PULSE_CNT_MAX=3).
// The model counts tick edges arithmetically: a tick falls on every edge k
// with k divisible by SAMPLE_CNT_MAX (k counted from reset release). A bit
// is qualified when at least PULSE_CNT_MAX ticks lie strictly after the
// last edge that saw its input low.
module tb_debouncer;

  localparam int W      = 2;
  localparam int S_MAX  = 4;
  localparam int P_MAX  = 3;
  localparam int BUDGET = 2000;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] glitchy_signal;
  logic [W-1:0] debounced_signal;

  int vectors;
  int miscompares;

  // model state
  int k;
  int last_low [W];

  debouncer #(
    .WIDTH          (W),
    .SAMPLE_CNT_MAX (S_MAX),
    .PULSE_CNT_MAX  (P_MAX)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .glitchy_signal   (glitchy_signal),
    .debounced_signal (debounced_signal)
  );

  initial clk = 1'b0;
  always #4 clk = ~clk;

  // model: edge counter and last-low edge per bit
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k = 0;
      for (int b = 0; b < W; b++) last_low[b] = 0;
    end else begin
      k = k + 1;
      for (int b = 0; b < W; b++)
        if (!glitchy_signal[b]) last_low[b] = k;
    end
  end

  function automatic logic [W-1:0] model_out();
    logic [W-1:0] r;
    r = '0;
    for (int b = 0; b < W; b++)
      r[b] = rst_n && ((k / S_MAX - last_low[b] / S_MAX) >= P_MAX);
    return r;
  endfunction

  // per-cycle compare against the model
  always @(negedge clk) begin
    logic [W-1:0] e;
    e = model_out();
    vectors++;
    if (debounced_signal !== e) begin
      miscompares++;
      $display("FAIL model k=%0d rst_n=%0b got=%b exp=%b", k, rst_n, debounced_signal, e);
    end
  end

  task automatic check_lit(input string name, input logic [W-1:0] exp);
    vectors++;
    if (debounced_signal !== exp) begin
      miscompares++;
      $display("FAIL %s k=%0d got=%b exp=%b", name, k, debounced_signal, exp);
    end
  endtask

  // wait until the negedge following edge n
  task automatic goto(input int n);
    int guard;
    guard = 0;
    @(negedge clk);
    while (k != n && guard < BUDGET) begin
      @(negedge clk);
      guard++;
    end
    if (k != n) begin
      vectors++;
      miscompares++;
      $display("FAIL goto_timeout k=%0d want=%0d", k, n);
    end
  endtask

  initial begin
    vectors        = 0;
    miscompares    = 0;
    rst_n          = 1'b0;
    glitchy_signal = 2'b11;

    // 1: reset holds outputs low even with both inputs high
    repeat (5) @(negedge clk);
    check_lit("reset_low", 2'b00);
    glitchy_signal = 2'b01;
    #2 rst_n = 1'b1;          // release between edges
    #1 check_lit("release_no_glitch", 2'b00);

    // 2: clean press on bit 0; ticks at edges 4, 8, 12
    goto(11);
    check_lit("press_e11", 2'b00);
    goto(12);
    check_lit("press_e12", 2'b01);

    // 3: bit 1 high from edge 13, ticks at 16, 20, low glitch sampled at 21
    glitchy_signal = 2'b11;
    goto(20);
    check_lit("bounce_pre", 2'b01);
    glitchy_signal = 2'b01;
    goto(21);
    glitchy_signal = 2'b11;
    goto(31);
    check_lit("bounce_e31", 2'b01);
    goto(32);
    check_lit("bounce_e32", 2'b11);

    // 4: release bit 0 so the low lands on the tick edge 36
    goto(35);
    glitchy_signal = 2'b10;
    goto(36);
    check_lit("release_e36", 2'b10);

    // low on a tick edge while counting: clear wins (bit 0 cnt 2 at 44, low at 48)
    glitchy_signal = 2'b11;
    goto(47);
    check_lit("tick_low_pre", 2'b10);
    glitchy_signal = 2'b10;
    goto(48);
    check_lit("tick_low_e48", 2'b10);
    glitchy_signal = 2'b11;
    goto(59);
    check_lit("tick_low_e59", 2'b10);
    goto(60);
    check_lit("tick_low_e60", 2'b11);

    // 5: saturation, hold for 100 cycles
    repeat (100) @(negedge clk);
    check_lit("saturate", 2'b11);

    // 6: reset mid-count after two fresh ticks
    glitchy_signal = 2'b00;
    goto(161);
    glitchy_signal = 2'b11;
    goto(169);                // ticks at 164, 168 seen
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_lit("midcount_reset", 2'b00);
    #2 rst_n = 1'b1;
    goto(11);
    check_lit("restart_e11", 2'b00);
    goto(12);
    check_lit("restart_e12", 2'b11);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_debouncer
